decoder_3_to_8: RTL and testbench

Registered 3-to-8 one-hot decoder with an active-high enable. Each clock edge samples a 3-bit select and an enable. The next cycle, the block drives an 8-bit output with exactly one bit set (bit index = select) when enabled, or all zeros when disabled. It sits between control logic that produces a binary index and downstream logic needing one-hot selects (chip selects, register-bank write strobes, mux selects).

---
 rtl/decoder_3_to_8.sv | 67 ++++++
 tb/tb_decoder_3_to_8.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/decoder_3_to_8.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_3_to_8
//  Description : Registered 3-to-8 one-hot decoder with active-high enable.
//                Each rising clock edge samples the 3-bit select and the
//                enable. One cycle later, out holds a single set bit at the
//                selected index when enable was high. When enable was low,
//                out holds all zeros. valid is a registered copy of enable.
//
//  Ports       : clk     in   1  system clock, rising edge
//                rst_n   in   1  asynchronous active-low reset
//                in      in   3  binary select index
//                enable  in   1  decode enable, active high
//                out     out  8  registered one-hot decode
//                valid   out  1  high when out holds a decoded value
//
//  Revision    : 1.0  initial release
// ============================================================================
module decoder_3_to_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] in,
    input  logic       enable,
    output logic [7:0] out,
    output logic       valid
);

    localparam logic [7:0] C_ZERO = 8'h00;

    logic [7:0] w_onehot;
    logic [7:0] r_out;
    logic       r_valid;

    // The decode is gated by enable before it reaches the register. An
    // unknown select therefore cannot reach out while the block is disabled.
    always_comb begin
        w_onehot = C_ZERO;
        if (enable) begin
            case (in)
                3'd0:    w_onehot = 8'h01;
                3'd1:    w_onehot = 8'h02;
                3'd2:    w_onehot = 8'h04;
                3'd3:    w_onehot = 8'h08;
                3'd4:    w_onehot = 8'h10;
                3'd5:    w_onehot = 8'h20;
                3'd6:    w_onehot = 8'h40;
                3'd7:    w_onehot = 8'h80;
                default: w_onehot = C_ZERO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= C_ZERO;
            r_valid <= 1'b0;
        end else begin
            r_out   <= w_onehot;
            r_valid <= enable;
        end
    end

    assign out   = r_out;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3_to_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_3_to_8
//  Description : Scoreboard testbench for decoder_3_to_8. The stimulus
//                process pushes the expected {out, valid} onto a queue.
//                The monitor pops one entry after every rising edge and
//                compares it against the DUT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decoder_3_to_8;

    logic       clk;
    logic       rst_n;
    logic [2:0] in;
    logic       enable;
    logic [7:0] out;
    logic       valid;

    typedef struct packed {
        logic [7:0] out;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];
    logic mon_en;
    int   n_checks;
    int   n_pass;

    decoder_3_to_8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .enable (enable),
        .out    (out),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    endtask

    // Reference model: with enable high, the one-hot value is two to the
    // power of the select. With enable low, the value is zero.
    function automatic exp_t model(input logic en, input logic [2:0] sel);
        exp_t e;
        int   v;
        v       = en ? (2 ** int'(sel)) : 0;
        e.out   = v[7:0];
        e.valid = en;
        return e;
    endfunction

    task automatic drive(input logic en, input logic [2:0] sel);
        @(negedge clk);
        enable = en;
        in     = sel;
        exp_q.push_back(model(en, sel));
    endtask

    // Monitor: runs after each rising edge and is decoupled from stimulus.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            check("onehot_or_zero", {8'h00, ($countones(out) <= 1)}, 9'h001);
            check("valid_iff_nonzero", {8'h00, valid}, {8'h00, (out != 8'h00)});
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out", {1'b0, out}, {1'b0, e.out});
                check("valid", {8'h00, valid}, {8'h00, e.valid});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        enable   = 1'b1;
        in       = 3'd4;

        // Reset values while held in reset.
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", {1'b0, out}, 9'h000);
        check("reset_valid", {8'h00, valid}, 9'h000);

        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b0;
        mon_en = 1'b1;

        // Disabled: in is ignored.
        drive(1'b0, 3'd0);
        drive(1'b0, 3'd5);

        // Full sweep.
        for (int i = 0; i < 8; i++) drive(1'b1, 3'(i));

        // Enable toggle with in held.
        drive(1'b1, 3'd3);
        drive(1'b0, 3'd3);
        drive(1'b1, 3'd3);

        // Inter-edge glitch: out keeps the previous value (08) until the edge.
        drive(1'b1, 3'd2);
        #2 in = 3'd6;
        check("glitch_hold_a", {1'b0, out}, 9'h008);
        #2 in = 3'd2;
        check("glitch_hold_b", {1'b0, out}, 9'h008);

        // Asynchronous reset in mid-cycle while out = 80.
        drive(1'b1, 3'd7);
        @(posedge clk);
        #2;
        check("pre_reset_out", {1'b0, out}, 9'h080);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_out", {1'b0, out}, 9'h000);
        check("async_reset_valid", {8'h00, valid}, 9'h000);
        enable = 1'b1;
        in     = 3'd5;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_held_out", {1'b0, out}, 9'h000);
            check("reset_held_valid", {8'h00, valid}, 9'h000);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b0;
        mon_en = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 1000; i++)
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("scoreboard_drained", {1'b0, 8'(exp_q.size())}, 9'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
